// File: rtl/pll_cfg_pkg.sv
// -----------------------------------------------------------------------------
// pll_cfg_pkg
// Shared definitions for the PLL configuration controller:
//   - 3-bit FSM state encoding
//   - divider reset defaults driven while no configuration has been applied
//   - lock counter width
// -----------------------------------------------------------------------------
package pll_cfg_pkg;

    localparam int LOCK_CNT_W = 20;

    localparam logic [2:0] ST_BYPASS = 3'd0;
    localparam logic [2:0] ST_RESET  = 3'd1;
    localparam logic [2:0] ST_WAIT   = 3'd2;
    localparam logic [2:0] ST_LOCKED = 3'd3;
    localparam logic [2:0] ST_FAIL   = 3'd4;

    localparam logic [7:0]  REFDIV_RST   = 8'd1;
    localparam logic [11:0] FBDIV_RST    = 12'd1;
    localparam logic [3:0]  POSTDIV1_RST = 4'd1;
    localparam logic [1:0]  POSTDIV2_RST = 2'd0;

endpackage

// File: rtl/pll_lock_sync.sv
// -----------------------------------------------------------------------------
// pll_lock_sync
// Two-flop synchronizer bringing the raw PLL lock into the clk_i domain.
// Ports:
//   clk_i   : destination clock
//   rst_n_i : asynchronous active-low reset, flops clear to 0
//   d_i     : asynchronous input
//   q_o     : synchronized output (two-cycle latency)
// -----------------------------------------------------------------------------
module pll_lock_sync (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_r;
    logic sync_r;

    // Two-stage capture of the asynchronous lock level
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= d_i;
            sync_r <= meta_r;
        end
    end

    assign q_o = sync_r;

endmodule

// File: rtl/pll_cfg_ctrl.sv
// -----------------------------------------------------------------------------
// pll_cfg_ctrl
// Configuration and lock-sequencing controller placed in front of the PLL
// wrapper. A configuration is accepted over valid/ready, the PLL is held in
// reset for RST_HOLD_CYC cycles, then the controller waits for a synchronized
// lock before letting downstream muxing select the PLL clock. Lock timeout
// and lock loss raise a sticky error.
//
// Optional feature macro: PLL_CFG_TIMEOUT_EN
//   defined   : 20-bit saturating lock counter, WAIT->FAIL after LOCK_TIMEOUT
//   undefined : WAIT waits indefinitely; FAIL only via lock loss
//
// Ports:
//   clk_i, rst_n_i          : reference clock, async active-low reset
//   cfg_valid_i/cfg_ready_o : configuration handshake
//   cfg_*_i                 : requested dividers and bypass
//   pll_lock_i              : raw asynchronous PLL lock
//   refdiv_o .. postdiv2_o  : registered PLL dividers
//   bp_o, pll_rst_n_o       : PLL bypass and active-low reset
//   clk_sel_o               : 1 = PLL clock usable downstream
//   cfg_done_o              : one-cycle completion pulse
//   err_o                   : sticky timeout / lock-loss flag
//   state_o                 : current FSM state
// -----------------------------------------------------------------------------
module pll_cfg_ctrl
    import pll_cfg_pkg::*;
#(
    parameter int                    RST_HOLD_CYC = 16,
    parameter logic [LOCK_CNT_W-1:0] LOCK_TIMEOUT = 20'h3FFFF
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        cfg_valid_i,
    output logic        cfg_ready_o,
    input  logic [7:0]  cfg_refdiv_i,
    input  logic [11:0] cfg_fbdiv_i,
    input  logic [3:0]  cfg_postdiv1_i,
    input  logic [1:0]  cfg_postdiv2_i,
    input  logic        cfg_bp_i,
    input  logic        pll_lock_i,
    output logic [7:0]  refdiv_o,
    output logic [11:0] fbdiv_o,
    output logic [3:0]  postdiv1_o,
    output logic [1:0]  postdiv2_o,
    output logic        bp_o,
    output logic        pll_rst_n_o,
    output logic        clk_sel_o,
    output logic        cfg_done_o,
    output logic        err_o,
    output logic [2:0]  state_o
);

    localparam int HOLD_W = (RST_HOLD_CYC > 1) ? $clog2(RST_HOLD_CYC) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYC - 1);

    logic [2:0]        state_r, state_s;
    logic [HOLD_W-1:0] hold_cnt_r;
    logic              lock_sync_s;
    logic              accept_s;
    logic              hold_done_s;
    logic              timeout_s;

    logic [7:0]  refdiv_r,   refdiv_s;
    logic [11:0] fbdiv_r,    fbdiv_s;
    logic [3:0]  postdiv1_r, postdiv1_s;
    logic [1:0]  postdiv2_r, postdiv2_s;
    logic        bp_r,       bp_s;
    logic        pll_rst_n_r, pll_rst_n_s;
    logic        clk_sel_r,  clk_sel_s;
    logic        done_r,     done_s;
    logic        err_r,      err_s;

    pll_lock_sync u_lock_sync (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .d_i     (pll_lock_i),
        .q_o     (lock_sync_s)
    );

    assign cfg_ready_o = (state_r == ST_BYPASS) || (state_r == ST_LOCKED) ||
                         (state_r == ST_FAIL);
    assign accept_s    = cfg_valid_i && cfg_ready_o;
    assign hold_done_s = (hold_cnt_r == HOLD_LAST);

    // PLL reset hold counter: restarts on every accept, advances in RESET
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            hold_cnt_r <= '0;
        end else if (accept_s) begin
            hold_cnt_r <= '0;
        end else if ((state_r == ST_RESET) && !hold_done_s) begin
            hold_cnt_r <= hold_cnt_r + 1'b1;
        end else begin
            hold_cnt_r <= hold_cnt_r;
        end
    end

`ifdef PLL_CFG_TIMEOUT_EN
    logic [LOCK_CNT_W-1:0] lock_cnt_r;

    // Saturating lock-wait counter, zeroed on the edge entering WAIT
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            lock_cnt_r <= '0;
        end else if ((state_r == ST_RESET) && (state_s == ST_WAIT)) begin
            lock_cnt_r <= '0;
        end else if ((state_r == ST_WAIT) && (lock_cnt_r != {LOCK_CNT_W{1'b1}})) begin
            lock_cnt_r <= lock_cnt_r + 1'b1;
        end else begin
            lock_cnt_r <= lock_cnt_r;
        end
    end

    assign timeout_s = (state_r == ST_WAIT) && (lock_cnt_r == LOCK_TIMEOUT);
`else
    logic [LOCK_CNT_W-1:0] unused_timeout_s;

    assign unused_timeout_s = LOCK_TIMEOUT;
    assign timeout_s        = 1'b0;
`endif

    // State register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r <= ST_BYPASS;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; accept has priority, lock beats a coincident timeout
    always_comb begin
        state_s = state_r;
        if (accept_s) begin
            state_s = cfg_bp_i ? ST_BYPASS : ST_RESET;
        end else begin
            case (state_r)
                ST_BYPASS: state_s = ST_BYPASS;
                ST_RESET: begin
                    if (hold_done_s) begin
                        state_s = ST_WAIT;
                    end else begin
                        state_s = ST_RESET;
                    end
                end
                ST_WAIT: begin
                    if (lock_sync_s) begin
                        state_s = ST_LOCKED;
                    end else if (timeout_s) begin
                        state_s = ST_FAIL;
                    end else begin
                        state_s = ST_WAIT;
                    end
                end
                ST_LOCKED: begin
                    if (!lock_sync_s) begin
                        state_s = ST_FAIL;
                    end else begin
                        state_s = ST_LOCKED;
                    end
                end
                ST_FAIL: state_s = ST_FAIL;
                // Unused encodings park in FAIL, which is ready for a new config
                default: state_s = ST_FAIL;
            endcase
        end
    end

    // Next output values, derived from the transition being taken
    always_comb begin
        refdiv_s    = refdiv_r;
        fbdiv_s     = fbdiv_r;
        postdiv1_s  = postdiv1_r;
        postdiv2_s  = postdiv2_r;
        bp_s        = bp_r;
        pll_rst_n_s = pll_rst_n_r;
        clk_sel_s   = clk_sel_r;
        done_s      = 1'b0;
        err_s       = err_r;
        if (accept_s) begin
            refdiv_s    = cfg_refdiv_i;
            fbdiv_s     = cfg_fbdiv_i;
            postdiv1_s  = cfg_postdiv1_i;
            postdiv2_s  = cfg_postdiv2_i;
            bp_s        = cfg_bp_i;
            pll_rst_n_s = 1'b0;
            clk_sel_s   = 1'b0;
            err_s       = 1'b0;
            done_s      = cfg_bp_i;
        end else if ((state_s == ST_FAIL) && (state_r != ST_FAIL)) begin
            bp_s        = 1'b1;
            pll_rst_n_s = 1'b0;
            clk_sel_s   = 1'b0;
            err_s       = 1'b1;
        end else if ((state_r == ST_RESET) && (state_s == ST_WAIT)) begin
            pll_rst_n_s = 1'b1;
        end else if ((state_r == ST_WAIT) && (state_s == ST_LOCKED)) begin
            clk_sel_s   = 1'b1;
            done_s      = 1'b1;
        end else begin
            done_s      = 1'b0;
        end
    end

    // Output registers; reset keeps the PLL bypassed and in reset
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            refdiv_r    <= REFDIV_RST;
            fbdiv_r     <= FBDIV_RST;
            postdiv1_r  <= POSTDIV1_RST;
            postdiv2_r  <= POSTDIV2_RST;
            bp_r        <= 1'b1;
            pll_rst_n_r <= 1'b0;
            clk_sel_r   <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            refdiv_r    <= refdiv_s;
            fbdiv_r     <= fbdiv_s;
            postdiv1_r  <= postdiv1_s;
            postdiv2_r  <= postdiv2_s;
            bp_r        <= bp_s;
            pll_rst_n_r <= pll_rst_n_s;
            clk_sel_r   <= clk_sel_s;
            done_r      <= done_s;
            err_r       <= err_s;
        end
    end

    assign refdiv_o    = refdiv_r;
    assign fbdiv_o     = fbdiv_r;
    assign postdiv1_o  = postdiv1_r;
    assign postdiv2_o  = postdiv2_r;
    assign bp_o        = bp_r;
    assign pll_rst_n_o = pll_rst_n_r;
    assign clk_sel_o   = clk_sel_r;
    assign cfg_done_o  = done_r;
    assign err_o       = err_r;
    assign state_o     = state_r;

endmodule

// File: doc/pll_cfg_ctrl.md
# pll_cfg_ctrl

Configuration and lock-sequencing controller that sits directly upstream of the `tc_pll` PLL wrapper. It accepts a divider/bypass configuration over a valid/ready handshake and drives the PLL's divider, bypass and reset inputs. It then waits for a synchronized lock indication and only afterwards tells downstream clock muxing to select the PLL output. Lock timeout and lock loss are reported as a sticky error.

## Interface

Parameters:

- `RST_HOLD_CYC`, 16: cycles `pll_rst_n_o` is held low per reconfiguration (≥1).
- `LOCK_TIMEOUT`, 20'h3FFFF: cycles allowed in WAIT before failure (must exceed PLL lock time).

Ports:

- `clk_i` in 1: PLL reference clock; the block's only clock.
- `rst_n_i` in 1: reset, asynchronous, active-low.
- `cfg_valid_i` in 1: configuration request.
- `cfg_ready_o` out 1: controller can accept a configuration.
- `cfg_refdiv_i` in 8, `cfg_fbdiv_i` in 12, `cfg_postdiv1_i` in 4, `cfg_postdiv2_i` in 2, `cfg_bp_i` in 1: requested settings.
- `pll_lock_i` in 1: raw PLL lock, asynchronous to `clk_i`.
- `refdiv_o` out 8, `fbdiv_o` out 12, `postdiv1_o` out 4, `postdiv2_o` out 2: registered PLL dividers.
- `bp_o` out 1: PLL bypass.
- `pll_rst_n_o` out 1: PLL reset, active-low.
- `clk_sel_o` out 1: 1 = downstream may use the PLL clock.
- `cfg_done_o` out 1: one-cycle pulse when a configuration completes.
- `err_o` out 1: sticky timeout or lock-loss flag.
- `state_o` out 3: current FSM state.

## Operation

- States: BYPASS=0, RESET=1, WAIT=2, LOCKED=3, FAIL=4.
- Reset values:
  - `refdiv_o`=1, `fbdiv_o`=1, `postdiv1_o`=1, `postdiv2_o`=0.
  - `bp_o`=1, `pll_rst_n_o`=0, `clk_sel_o`=0, `cfg_done_o`=0, `err_o`=0, state BYPASS.
- `cfg_ready_o` = state ∈ {BYPASS, LOCKED, FAIL}. It is combinational from state.
- Accept (`cfg_valid_i & cfg_ready_o`):
  - Latch all five fields, clear `err_o`, drop `clk_sel_o` to 0 on the same edge.
  - If `cfg_bp_i`=1: `bp_o`=1, `pll_rst_n_o`=0, next state BYPASS, pulse `cfg_done_o`.
  - Otherwise: next state RESET, `pll_rst_n_o`=0, `bp_o`=0, hold counter cleared.
- RESET: count `RST_HOLD_CYC` cycles, then go to WAIT with `pll_rst_n_o`=1 and the lock counter cleared.
- WAIT:
  - Synchronized lock high → LOCKED; `clk_sel_o`=1 and `cfg_done_o` pulse on entry.
  - Timeout (see Configuration) → FAIL.
- LOCKED: synchronized lock falls → FAIL.
- FAIL: `err_o`=1, `bp_o`=1, `pll_rst_n_o`=0, `clk_sel_o`=0. The block stays in FAIL until a new configuration is accepted.
- Divider outputs change only on accept and stay stable through RESET/WAIT/LOCKED.
- `cfg_valid_i` during RESET/WAIT is ignored (ready=0); the requester holds valid until accepted.
- Async reset mid-sequence returns everything to reset values immediately; the PLL is held in reset.

## Timing

- Accept at edge T:
  - Outputs reflect new fields from T.
  - `pll_rst_n_o` low for cycles T..T+`RST_HOLD_CYC`-1, high from edge T+`RST_HOLD_CYC`.
- Lock synchronizer: 2 flops. A `pll_lock_i` rise setting up before edge L is seen in the FSM at L+1, and LOCKED plus `clk_sel_o`=1 are registered at edge L+2.
- Lock loss: same 2-cycle sync latency. `clk_sel_o` is cleared at the edge entering FAIL.
- Lock counter is 20-bit, saturating, counting from WAIT entry. FAIL is entered on the edge where the count equals `LOCK_TIMEOUT` with no synchronized lock.
- Lock arriving on the same edge as timeout: lock wins → LOCKED.
- `cfg_done_o` is exactly 1 cycle and never asserted together with FAIL.

## Configuration

- `PLL_CFG_TIMEOUT_EN`:
  - Defined: lock counter and WAIT→FAIL timeout are present.
  - Undefined: counter is removed; WAIT waits indefinitely, and FAIL is reachable only through lock loss from LOCKED.

## Structure

- Package `pll_cfg_pkg`: state encoding constants (3-bit), reset divider defaults, `LOCK_CNT_W`=20.
- Sub-module `pll_lock_sync`: 2-flop synchronizer with async active-low reset to 0.

## Test plan

- Reset release, no request → state 0, `bp_o`=1, `pll_rst_n_o`=0, `clk_sel_o`=0, ready=1.
- Config refdiv=2, fbdiv=100, postdiv1=4, postdiv2=1, bp=0; lock raised 50 cycles after `pll_rst_n_o` rises:
  - `pll_rst_n_o` low for exactly 16 cycles.
  - `clk_sel_o`=1 two cycles after lock.
  - One `cfg_done_o` pulse; outputs equal the requested values.
- Lock never rises (macro defined, `LOCK_TIMEOUT` overridden to 100) → FAIL at cycle 100 of WAIT, `err_o`=1, `bp_o`=1, `clk_sel_o`=0.
- In LOCKED, deassert `pll_lock_i` for 3 cycles → FAIL within 3 edges, `err_o` sticky after lock returns. A new config clears `err_o`.
- Bypass config (bp=1) from LOCKED → `clk_sel_o` drops on the accept edge, `pll_rst_n_o`=0, state BYPASS, single `cfg_done_o`.
- Assert `rst_n_i` during WAIT → all outputs at reset values asynchronously; a later config sequences normally.
